multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: when 1, memory states wait for MemReady; when 0, MemReady is treated as constant 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Op  input  6  instruction opcode field from the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 MemReady  input  1  memory handshake; access completes in the cycle it is 1.
REQ-007 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  standard multicycle datapath controls.
REQ-008 ALUSrcB  output  2  ALU B select: 00 reg, 01 const 4, 10 sign-ext imm, 11 shifted imm.
REQ-009 ALUOp  output  2  00 add, 01 subtract, 10 use Funct; drives the ALU function decode.
REQ-010 PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 PCEn  output  1  PC write enable = PCWrite | (Branch & Zero).
REQ-012 Illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-013 Busy  output  1  high in every state except FETCH.

Function
REQ-014 Moore FSM, 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JUMPEX.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite and PCWrite = MemReady; stay while MemReady=0, else -> DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by Op: 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 001000 -> ADDIEX, 000010 -> JUMPEX, other -> FETCH with Illegal=1 for this cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> MEMRD if Op=100011, else MEMWR.
REQ-018 MEMRD: IorD=1; hold until MemReady=1, then -> MEMWB.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-020 MEMWR: IorD=1, MemWrite=1 held every cycle until MemReady=1, then -> FETCH.
REQ-021 RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> ALUWB.
REQ-022 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-023 BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1; PCEn=Zero in that cycle; -> FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-025 JUMPEX: PCSrc=10, PCWrite=1; -> FETCH.
REQ-026 Every output not listed for a state is 0; outputs depend on state only, except PCEn/IRWrite (MemReady, Zero gated).
REQ-027 Instruction latencies with MemReady=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2 cycles.
REQ-028 Unreachable state encodings -> FETCH next cycle, outputs all 0 there.
REQ-029 Op sampled combinationally each cycle; Op change mid-instruction affects only DECODE/MEMADR decisions.

Reset
REQ-030 rst_n low forces state=FETCH immediately, asynchronously, mid-instruction included.
REQ-031 While rst_n low, IRWrite, PCEn, MemWrite, RegWrite, Illegal SHALL be 0; other outputs at FETCH values; Busy=0.
REQ-032 First FETCH after rst_n deasserts behaves per REQ-015.

Structure
REQ-033 Shared package holds state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), ALUOp and PCSrc encodings.
REQ-034 One sub-module, mc_state_decode: combinational state-to-control table; top holds state register and next-state logic.

Verification
REQ-035 Reset mid-MEMWR (MemWrite=1), rst_n low -> MemWrite=0 same cycle, state FETCH, Busy=0.
REQ-036 lw, MemReady=1 always -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 only in 5th cycle.
REQ-037 sw with MemReady low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-038 beq Zero=1 -> PCEn=1, PCSrc=01 in 3rd cycle; Zero=0 -> PCEn=0.
REQ-039 Op=111111 -> Illegal=1 one cycle in DECODE, next state FETCH, no write enables.
REQ-040 MEM_WAIT_EN=0, MemReady=0 forever, R-type -> completes in 4 cycles, ALUOp=10 in RTYPEEX.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// instruction opcodes, ALU-operation / PC-source / ALU-B-source encodings,
// the control-word structure produced by the state decoder, and a helper
// that tells whether an opcode is implemented.
package multicycle_controller_pkg;

  // 12 reachable states; the 4 spare encodings are treated as unreachable.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMPEX  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // Per-state control word. ready_gated marks the state whose IRWrite and
  // PCWrite are qualified by the memory handshake (instruction fetch).
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       ready_gated;
    logic       busy;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_controller_state_decode.sv
// mc_state_decode: purely combinational state-to-control table.
// Ports:
//   state_i  current FSM state
//   ctrl_o   raw control word for that state (not yet gated by MemReady,
//            Zero or reset; the top applies those qualifiers)
module mc_state_decode
  import multicycle_controller_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.alu_src_b   = ALUSRCB_FOUR;
        ctrl_o.alu_op      = ALUOP_ADD;
        ctrl_o.pc_src      = PCSRC_ALU;
        ctrl_o.ir_write    = 1'b1;
        ctrl_o.pc_write    = 1'b1;
        ctrl_o.ready_gated = 1'b1;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = ALUSRCB_IMMSH;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.busy      = 1'b1;
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.busy      = 1'b1;
      end
      ST_MEMRD: begin
        ctrl_o.iord = 1'b1;
        ctrl_o.busy = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.busy       = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.busy      = 1'b1;
      end
      ST_RTYPEEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
        ctrl_o.busy      = 1'b1;
      end
      ST_ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.busy      = 1'b1;
      end
      ST_BEQEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_REG;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
        ctrl_o.busy      = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.busy      = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.busy      = 1'b1;
      end
      ST_JUMPEX: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
        ctrl_o.busy     = 1'b1;
      end
      // Spare encodings: every control stays 0, Busy included.
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a classic multicycle datapath
// through fetch / decode / execute / memory / writeback.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   Op[5:0]               opcode from the instruction register
//   Zero                  ALU zero flag (used by beq)
//   MemReady              memory handshake, access completes when 1
//   IorD..ALUSrcA         single-bit datapath controls
//   ALUSrcB, ALUOp, PCSrc 2-bit datapath selects
//   PCEn                  PC write enable (PCWrite | Branch & Zero)
//   Illegal               one-cycle pulse in DECODE for unsupported opcodes
//   Busy                  high in every state except FETCH
// Parameter MEM_WAIT_EN: 0 makes every memory access complete immediately.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic       Busy
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   mem_ready;
  logic   ready_gate;

  assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

  mc_state_decode u_state_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Op is looked at only in DECODE and MEMADR, so a change
  // on Op during other states has no effect on sequencing.
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:   state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPEEX;
          OP_BEQ:       state_d = ST_BEQEX;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMPEX;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_d = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:   state_d = ST_FETCH;
      ST_MEMWR:   state_d = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_RTYPEEX: state_d = ST_ALUWB;
      ST_ALUWB:   state_d = ST_FETCH;
      ST_BEQEX:   state_d = ST_FETCH;
      ST_ADDIEX:  state_d = ST_ADDIWB;
      ST_ADDIWB:  state_d = ST_FETCH;
      ST_JUMPEX:  state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Output logic. The state register is already FETCH while rst_n is low, so
  // only the enables that could still fire in FETCH (or that must never
  // glitch high during reset) need an explicit rst_n qualifier.
  always_comb begin
    ready_gate = ctrl.ready_gated ? mem_ready : 1'b1;
    IorD       = ctrl.iord;
    MemWrite   = rst_n & ctrl.mem_write;
    IRWrite    = rst_n & ctrl.ir_write & ready_gate;
    RegDst     = ctrl.reg_dst;
    MemtoReg   = ctrl.mem_to_reg;
    RegWrite   = rst_n & ctrl.reg_write;
    ALUSrcA    = ctrl.alu_src_a;
    ALUSrcB    = ctrl.alu_src_b;
    ALUOp      = ctrl.alu_op;
    PCSrc      = ctrl.pc_src;
    PCEn       = rst_n & ((ctrl.pc_write & ready_gate) | (ctrl.branch & Zero));
    Illegal    = rst_n & (state_q == ST_DECODE) & ~op_supported(Op);
    Busy       = ctrl.busy;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       mr2;

  logic       a_iord, a_mw, a_irw, a_rd, a_m2r, a_rw, a_asa, a_pcen, a_ill, a_busy;
  logic [1:0] a_asb, a_aop, a_pcs;
  logic       b_iord, b_mw, b_irw, b_rd, b_m2r, b_rw, b_asa, b_pcen, b_ill, b_busy;
  logic [1:0] b_asb, b_aop, b_pcs;
  logic [15:0] obs1, obs2;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        ready;
    logic [15:0] exp;
  } stim_t;

  stim_t       stim_q[$];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .IorD(a_iord), .MemWrite(a_mw), .IRWrite(a_irw), .RegDst(a_rd),
    .MemtoReg(a_m2r), .RegWrite(a_rw), .ALUSrcA(a_asa), .ALUSrcB(a_asb),
    .ALUOp(a_aop), .PCSrc(a_pcs), .PCEn(a_pcen), .Illegal(a_ill), .Busy(a_busy)
  );

  multicycle_controller #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemReady(mr2),
    .IorD(b_iord), .MemWrite(b_mw), .IRWrite(b_irw), .RegDst(b_rd),
    .MemtoReg(b_m2r), .RegWrite(b_rw), .ALUSrcA(b_asa), .ALUSrcB(b_asb),
    .ALUOp(b_aop), .PCSrc(b_pcs), .PCEn(b_pcen), .Illegal(b_ill), .Busy(b_busy)
  );

  assign obs1 = {a_iord, a_mw, a_irw, a_rd, a_m2r, a_rw, a_asa, a_asb, a_aop, a_pcs, a_pcen, a_ill, a_busy};
  assign obs2 = {b_iord, b_mw, b_irw, b_rd, b_m2r, b_rw, b_asa, b_asb, b_aop, b_pcs, b_pcen, b_ill, b_busy};
  assign mr2  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control words, written straight from the per-state output table.
  // Bit order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
  //            ALUSrcB[2] ALUOp[2] PCSrc[2] PCEn Illegal Busy
  function automatic logic [15:0] vec(input logic iord, mw, irw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, aop, pcs,
                                      input logic pcen, ill, busy);
    return {iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcen, ill, busy};
  endfunction

  function automatic logic [15:0] e_fetch(input logic r);
    return vec(0, 0, r, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, r, 0, 0);
  endfunction
  function automatic logic [15:0] e_decode(input logic ill);
    return vec(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, ill, 1);
  endfunction
  function automatic logic [15:0] e_memadr();
    return vec(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_memrd();
    return vec(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_memwb();
    return vec(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_memwr();
    return vec(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_rtypeex();
    return vec(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_aluwb();
    return vec(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_beqex(input logic z);
    return vec(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, z, 0, 1);
  endfunction
  function automatic logic [15:0] e_addiex();
    return vec(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_addiwb();
    return vec(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
  endfunction
  function automatic logic [15:0] e_jumpex();
    return vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 1);
  endfunction

  task automatic add(input logic [5:0] op, input logic z, input logic r, input logic [15:0] e);
    stim_t s;
    s.op = op; s.zero = z; s.ready = r; s.exp = e;
    stim_q.push_back(s);
  endtask

  // Drives one cycle's inputs just after the rising edge and records the
  // output word expected for that cycle.
  task automatic drive_cycle(input stim_t s);
    @(posedge clk);
    #1;
    Op = s.op; Zero = s.zero; MemReady = s.ready;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst_n = 1'b0; MemReady = 1'b1; Op = OP_LW; Zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = e_fetch(1'b0);
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs1, e);
      end
    end
    MemReady = 1'b0; Zero = 1'b0;
    rst_n = 1'b1;
    add(OP_LW, 1'b0, 1'b0, e_fetch(1'b0));
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL reset_first_fetch got=%h exp=%h", obs1, e);
      end
    end
    $display("TXN reset done");
  endtask

  task automatic test_lw();
    logic [15:0] e;
    int n = 0;
    add(OP_LW, 0, 1, e_fetch(1));
    add(OP_LW, 0, 1, e_decode(0));
    add(OP_LW, 0, 1, e_memadr());
    add(OP_LW, 0, 1, e_memrd());
    add(OP_LW, 0, 1, e_memwb());
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL lw cyc%0d got=%h exp=%h", n, obs1, e);
      end
      n++;
    end
    $display("TXN lw cycles=%0d", n);
  endtask

  task automatic test_sw_wait();
    logic [15:0] e;
    int n = 0;
    add(OP_SW, 0, 0, e_fetch(0));
    add(OP_SW, 0, 1, e_fetch(1));
    add(OP_SW, 0, 1, e_decode(0));
    add(OP_SW, 0, 1, e_memadr());
    add(OP_SW, 0, 0, e_memwr());
    add(OP_SW, 0, 0, e_memwr());
    add(OP_SW, 0, 0, e_memwr());
    add(OP_SW, 0, 1, e_memwr());
    add(OP_SW, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL sw_wait cyc%0d got=%h exp=%h", n, obs1, e);
      end
      n++;
    end
    $display("TXN sw_wait cycles=%0d", n);
  endtask

  task automatic test_beq();
    logic [15:0] e;
    int n = 0;
    add(OP_BEQ, 1, 1, e_fetch(1));
    add(OP_BEQ, 1, 1, e_decode(0));
    add(OP_BEQ, 1, 1, e_beqex(1));
    add(OP_BEQ, 1, 1, e_fetch(1));
    add(OP_BEQ, 1, 1, e_decode(0));
    add(OP_BEQ, 0, 1, e_beqex(0));
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL beq cyc%0d got=%h exp=%h", n, obs1, e);
      end
      n++;
    end
    $display("TXN beq taken+not_taken cycles=%0d", n);
  endtask

  task automatic test_illegal();
    logic [15:0] e;
    int n = 0;
    add(6'b111111, 0, 1, e_fetch(1));
    add(6'b111111, 0, 1, e_decode(1));
    add(6'b111111, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL illegal cyc%0d got=%h exp=%h", n, obs1, e);
      end
      n++;
    end
    $display("TXN illegal cycles=%0d", n);
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int n = 0;
    // R-type; Op changing after DECODE must not disturb it or raise Illegal.
    add(OP_RTYPE, 0, 1, e_fetch(1));
    add(OP_RTYPE, 0, 1, e_decode(0));
    add(6'b111111, 0, 1, e_rtypeex());
    add(6'b111111, 0, 1, e_aluwb());
    // addi
    add(OP_ADDI, 0, 1, e_fetch(1));
    add(OP_ADDI, 0, 1, e_decode(0));
    add(OP_ADDI, 0, 1, e_addiex());
    add(OP_ADDI, 0, 1, e_addiwb());
    // j
    add(OP_J, 0, 1, e_fetch(1));
    add(OP_J, 0, 1, e_decode(0));
    add(OP_J, 0, 1, e_jumpex());
    // lw with two wait cycles in MEMRD
    add(OP_LW, 0, 1, e_fetch(1));
    add(OP_LW, 0, 1, e_decode(0));
    add(OP_LW, 0, 1, e_memadr());
    add(OP_LW, 0, 0, e_memrd());
    add(OP_LW, 0, 0, e_memrd());
    add(OP_LW, 0, 1, e_memrd());
    add(OP_LW, 0, 1, e_memwb());
    // lw decoded, Op switched to sw while in MEMADR -> store path
    add(OP_LW, 0, 1, e_fetch(1));
    add(OP_LW, 0, 1, e_decode(0));
    add(OP_SW, 0, 1, e_memadr());
    add(OP_SW, 0, 1, e_memwr());
    add(OP_SW, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL back_to_back cyc%0d got=%h exp=%h", n, obs1, e);
      end
      n++;
    end
    $display("TXN back_to_back cycles=%0d", n);
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] e;
    int n = 0;
    add(OP_SW, 0, 1, e_fetch(1));
    add(OP_SW, 0, 1, e_decode(0));
    add(OP_SW, 0, 1, e_memadr());
    add(OP_SW, 0, 0, e_memwr());
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL reset_mid_write cyc%0d got=%h exp=%h", n, obs1, e);
      end
      n++;
    end
    // Asynchronous reset between clock edges, with MemReady high to make
    // sure the fetch enables stay suppressed.
    #2;
    MemReady = 1'b1;
    rst_n = 1'b0;
    #1;
    e = e_fetch(1'b0);
    checks++;
    if (obs1 !== e) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs1, e);
    end
    @(negedge clk);
    checks++;
    if (obs1 !== e) begin
      failures++;
      $display("FAIL reset_async_hold got=%h exp=%h", obs1, e);
    end
    MemReady = 1'b0;
    rst_n = 1'b1;
    add(OP_SW, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        failures++;
        $display("FAIL reset_mid_write_after got=%h exp=%h", obs1, e);
      end
    end
    $display("TXN reset_mid_write done");
  endtask

  task automatic test_no_wait();
    logic [15:0] e;
    int n = 1;
    @(negedge clk);
    #1;
    rst_n = 1'b0; Op = OP_RTYPE; Zero = 1'b0; MemReady = 1'b0;
    @(negedge clk);
    e = e_fetch(1'b0);
    checks++;
    if (obs2 !== e) begin
      failures++;
      $display("FAIL nowait_reset got=%h exp=%h", obs2, e);
    end
    rst_n = 1'b1;
    #1;
    // MemReady tied low, yet the access completes at once in FETCH.
    e = e_fetch(1'b1);
    checks++;
    if (obs2 !== e) begin
      failures++;
      $display("FAIL nowait_fetch got=%h exp=%h", obs2, e);
    end
    add(OP_RTYPE, 0, 0, e_decode(0));
    add(OP_RTYPE, 0, 0, e_rtypeex());
    add(OP_RTYPE, 0, 0, e_aluwb());
    add(OP_RTYPE, 0, 0, e_fetch(1));
    while (stim_q.size() > 0) begin
      drive_cycle(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs2 !== e) begin
        failures++;
        $display("FAIL nowait_rtype cyc%0d got=%h exp=%h", n, obs2, e);
      end
      n++;
    end
    $display("TXN nowait_rtype cycles=%0d", n - 1);
  endtask

  initial begin
    rst_n = 1'b0; Op = '0; Zero = 1'b0; MemReady = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid_write();
    test_no_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
